copy_arb2: RTL and testbench

COPY_ARB2 -- requirements
Module: copy_arb2

---
 rtl/copy_arb2.sv | 122 ++++++++++++
 tb/tb_copy_arb2.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/copy_arb2.sv
// Two-requester round-robin arbiter forwarding one packet at a time to a COPY stage
// over 4-phase level handshakes, counting forwarded packets whose copy flag is set.
module copy_arb2 #(
  parameter int PKT_W   = 32,
  parameter int CPY_BIT = 31
) (
  input  logic             CLK,
  input  logic             MR_N,
  input  logic             Send_in0,
  input  logic             Send_in1,
  input  logic [PKT_W-1:0] PACKET_IN0,
  input  logic [PKT_W-1:0] PACKET_IN1,
  output logic             Ack_out0,
  output logic             Ack_out1,
  output logic             Send_out,
  output logic [PKT_W-1:0] PACKET_OUT,
  input  logic             Ack_in,
  output logic             GNT_ID,
  output logic [15:0]      CPY_CNT
);

  typedef enum logic [1:0] {IDLE, ACK_UP, SEND, RTZ} state_e;

  state_e             state_q, state_d;
  logic [1:0]         req_meta_q, req_sync_q;
  logic               ack_meta_q, ack_sync_q;
  logic               pri_q, pri_d;
  logic               gnt_q, gnt_d;
  logic [1:0]         ack_out_q, ack_out_d;
  logic               send_q, send_d;
  logic [PKT_W-1:0]   pkt_q, pkt_d;
  logic [15:0]        cpy_cnt_q, cpy_cnt_d;
  logic               win;

  // Two-stage synchronizers; nothing downstream looks at the raw asynchronous levels.
  always_ff @(posedge CLK or negedge MR_N) begin
    if (!MR_N) begin
      req_meta_q <= '0;
      req_sync_q <= '0;
      ack_meta_q <= 1'b0;
      ack_sync_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let each flop sample the previous stage's old value.
      req_meta_q <= {Send_in1, Send_in0};
      req_sync_q <= req_meta_q;
      ack_meta_q <= Ack_in;
      ack_sync_q <= ack_meta_q;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_d   = state_q;
    pri_d     = pri_q;
    gnt_d     = gnt_q;
    ack_out_d = ack_out_q;
    send_d    = send_q;
    pkt_d     = pkt_q;
    cpy_cnt_d = cpy_cnt_q;
    win       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|req_sync_q) begin
          // Contention goes to the pointer; a lone request wins outright.
          win       = (req_sync_q == 2'b11) ? pri_q : req_sync_q[1];
          gnt_d     = win;
          pri_d     = ~win;
          pkt_d     = win ? PACKET_IN1 : PACKET_IN0;
          ack_out_d = win ? 2'b10 : 2'b01;
          state_d   = ACK_UP;
        end
      end
      ACK_UP: begin
        if (!req_sync_q[gnt_q]) begin
          ack_out_d = 2'b00;
          send_d    = 1'b1;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (ack_sync_q) begin
          send_d  = 1'b0;
          state_d = RTZ;
          if (pkt_q[CPY_BIT]) cpy_cnt_d = cpy_cnt_q + 16'd1;
        end
      end
      RTZ: begin
        if (!ack_sync_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge MR_N) begin
    if (!MR_N) begin
      state_q   <= IDLE;
      pri_q     <= 1'b0;
      gnt_q     <= 1'b0;
      ack_out_q <= 2'b00;
      send_q    <= 1'b0;
      pkt_q     <= '0;
      cpy_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pri_q     <= pri_d;
      gnt_q     <= gnt_d;
      ack_out_q <= ack_out_d;
      send_q    <= send_d;
      pkt_q     <= pkt_d;
      cpy_cnt_q <= cpy_cnt_d;
    end
  end

  assign Ack_out0   = ack_out_q[0];
  assign Ack_out1   = ack_out_q[1];
  assign Send_out   = send_q;
  assign PACKET_OUT = pkt_q;
  assign GNT_ID     = gnt_q;
  assign CPY_CNT    = cpy_cnt_q;

endmodule

// File: tb/tb_copy_arb2.sv
// Scoreboard bench for copy_arb2: a round-robin model predicts grant order, packets
// and copy counts; a monitor checks each transfer as the DUT presents it.
module tb_copy_arb2;
  localparam int PKT_W   = 32;
  localparam int CPY_BIT = 31;

  logic             CLK = 1'b0;
  logic             MR_N = 1'b0;
  logic             Send_in0 = 1'b0, Send_in1 = 1'b0;
  logic [PKT_W-1:0] PACKET_IN0 = '0, PACKET_IN1 = '0;
  logic             Ack_in = 1'b0;
  logic             Ack_out0, Ack_out1, Send_out, GNT_ID;
  logic [PKT_W-1:0] PACKET_OUT;
  logic [15:0]      CPY_CNT;

  copy_arb2 #(.PKT_W(PKT_W), .CPY_BIT(CPY_BIT)) dut (
    .CLK(CLK), .MR_N(MR_N),
    .Send_in0(Send_in0), .Send_in1(Send_in1),
    .PACKET_IN0(PACKET_IN0), .PACKET_IN1(PACKET_IN1),
    .Ack_out0(Ack_out0), .Ack_out1(Ack_out1),
    .Send_out(Send_out), .PACKET_OUT(PACKET_OUT),
    .Ack_in(Ack_in), .GNT_ID(GNT_ID), .CPY_CNT(CPY_CNT)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: round-robin pointer, copy counter, expected transfer queue.
  typedef struct {
    bit               id;
    logic [PKT_W-1:0] pkt;
    logic [15:0]      cnt;
  } exp_t;

  exp_t        exp_q[$];
  bit          m_pri = 1'b0;
  logic [15:0] m_cnt = '0;

  function automatic void model_push(input bit id, input logic [PKT_W-1:0] pkt);
    exp_t e;
    m_pri = ~id;
    if (pkt[CPY_BIT]) m_cnt = m_cnt + 16'd1;
    e.id  = id;
    e.pkt = pkt;
    e.cnt = m_cnt;
    exp_q.push_back(e);
  endfunction

  function automatic logic ack_of(input bit id);
    return id ? Ack_out1 : Ack_out0;
  endfunction

  // Monitor: a rising Send_out presents a transfer, a falling one closes it.
  initial begin : monitor
    bit   prev = 1'b0;
    bit   live = 1'b0;
    exp_t cur;
    forever begin
      @(negedge CLK);
      if (!MR_N) begin
        live = 1'b0;
        prev = 1'b0;
      end else begin
        if (Send_out && !prev) begin
          if (exp_q.size() == 0) begin
            check("unexpected_transfer", 1'b1, 1'b0);
            live = 1'b0;
          end else begin
            cur  = exp_q.pop_front();
            live = 1'b1;
            check("gnt_id", GNT_ID, cur.id);
            check("packet_out", PACKET_OUT, cur.pkt);
          end
        end else if (Send_out && live) begin
          check("packet_hold", PACKET_OUT, cur.pkt);
        end
        if (!Send_out && prev && live) begin
          check("cpy_cnt", CPY_CNT, cur.cnt);
          live = 1'b0;
        end
        if (Ack_out0 || Ack_out1)
          check("ack_matches_gnt", {Ack_out1, Ack_out0}, GNT_ID ? 2'b10 : 2'b01);
        prev = Send_out;
      end
    end
  end

  // COPY-stage responder with random acknowledge delays.
  initial begin : responder
    forever begin
      @(negedge CLK);
      if (Send_out && !Ack_in) begin
        repeat ($urandom_range(0, 3)) @(negedge CLK);
        Ack_in = 1'b1;
      end else if (!Send_out && Ack_in) begin
        repeat ($urandom_range(0, 3)) @(negedge CLK);
        Ack_in = 1'b0;
      end
    end
  end

  task automatic requester(input bit id, input logic [PKT_W-1:0] pkt, input bit chk_lat);
    int cyc = 0;
    if (id) begin Send_in1 = 1'b1; PACKET_IN1 = pkt; end
    else    begin Send_in0 = 1'b1; PACKET_IN0 = pkt; end
    while (!ack_of(id) && cyc < 400) begin @(negedge CLK); cyc++; end
    if (!ack_of(id)) check("ack_rise_timeout", 1'b0, 1'b1);
    else if (chk_lat) check("grant_latency", cyc, 3);
    if (id) Send_in1 = 1'b0; else Send_in0 = 1'b0;
    cyc = 0;
    while (ack_of(id) && cyc < 400) begin @(negedge CLK); cyc++; end
    if (ack_of(id)) check("ack_fall_timeout", 1'b1, 1'b0);
  endtask

  task automatic wait_idle();
    int cyc = 0;
    while ((Send_out || Ack_in || Ack_out0 || Ack_out1) && cyc < 500) begin
      @(negedge CLK); cyc++;
    end
    if (Send_out || Ack_in) check("idle_timeout", 1'b1, 1'b0);
    repeat (6) @(negedge CLK);
  endtask

  task automatic round(input logic [1:0] mask, input logic [PKT_W-1:0] p0, input logic [PKT_W-1:0] p1);
    bit first;
    wait_idle();
    first = (mask == 2'b11) ? m_pri : mask[1];
    model_push(first, first ? p1 : p0);
    if (mask == 2'b11) model_push(~first, first ? p0 : p1);
    fork
      if (mask[0]) requester(1'b0, p0, first == 1'b0);
      if (mask[1]) requester(1'b1, p1, first == 1'b1);
    join
  endtask

  initial begin : stimulus
    logic [PKT_W-1:0] pa, pb;
    logic [1:0]       mask;
    bit               saw_drop;
    int               cyc;

    repeat (3) @(negedge CLK);
    check("rst_send_out", Send_out, 1'b0);
    check("rst_acks", {Ack_out1, Ack_out0}, 2'b00);
    check("rst_packet_out", PACKET_OUT, '0);
    check("rst_cpy_cnt", CPY_CNT, 16'h0);
    check("rst_gnt_id", GNT_ID, 1'b0);
    MR_N = 1'b1;

    // Simultaneous requests: 0 first after reset, then alternate.
    round(2'b11, 32'h0000_0A00, 32'h0000_0B00);
    round(2'b11, 32'h0000_0A01, 32'h0000_0B01);

    // Single request.
    round(2'b01, 32'h0000_1234, 32'h0);

    // Copy flag: three set, two clear.
    round(2'b01, 32'h8000_0001, 32'h0);
    round(2'b10, 32'h0, 32'h0000_0002);
    round(2'b10, 32'h0, 32'h8000_0003);
    round(2'b01, 32'h0000_0004, 32'h0);
    round(2'b11, 32'h8000_0005, 32'h8000_0006);

    // Late request from 1 while 0 is in SEND.
    wait_idle();
    pa = 32'h8000_1111;
    pb = 32'h0000_2222;
    model_push(1'b0, pa);
    model_push(1'b1, pb);
    fork
      requester(1'b0, pa, 1'b1);
      begin
        cyc = 0;
        while (!Send_out && cyc < 400) begin @(negedge CLK); cyc++; end
        Send_in1   = 1'b1;
        PACKET_IN1 = pb;
        saw_drop   = 1'b0;
        cyc        = 0;
        while (!Ack_out1 && cyc < 400) begin
          @(negedge CLK); cyc++;
          if (!Send_out) saw_drop = 1'b1;
        end
        check("late_req_after_send", saw_drop, 1'b1);
        Send_in1 = 1'b0;
        cyc = 0;
        while (Ack_out1 && cyc < 400) begin @(negedge CLK); cyc++; end
      end
    join

    // Randomized traffic.
    for (int i = 0; i < 20; i++) begin
      mask = 2'($urandom_range(1, 3));
      round(mask, $urandom, $urandom);
    end

    // Counter wrap.
    wait_idle();
    force dut.cpy_cnt_q = 16'hFFFF;
    @(negedge CLK);
    release dut.cpy_cnt_q;
    @(negedge CLK);
    check("forced_cnt", CPY_CNT, 16'hFFFF);
    m_cnt = 16'hFFFF;
    round(2'b01, 32'h8000_00FF, 32'h0);
    wait_idle();
    check("cnt_wrapped", CPY_CNT, 16'h0000);

    // Reset mid-SEND with a pending request from 1.
    pa = 32'h8000_3333;
    pb = 32'h8000_4444;
    model_push(1'b0, pa);
    requester(1'b0, pa, 1'b1);
    Send_in1   = 1'b1;
    PACKET_IN1 = pb;
    @(negedge CLK);
    check("in_send_before_reset", Send_out, 1'b1);
    MR_N = 1'b0;
    #1;
    check("abort_send_out", Send_out, 1'b0);
    check("abort_acks", {Ack_out1, Ack_out0}, 2'b00);
    check("abort_packet_out", PACKET_OUT, '0);
    check("abort_cpy_cnt", CPY_CNT, 16'h0);
    exp_q.delete();
    m_pri = 1'b0;
    m_cnt = '0;
    model_push(1'b1, pb);
    repeat (2) @(negedge CLK);
    MR_N = 1'b1;
    requester(1'b1, pb, 1'b1);

    wait_idle();
    check("final_cpy_cnt", CPY_CNT, m_cnt);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
